// File: rtl/alu_vec_pkg.sv
// Shared types and defaults for the vector ALU result path.
package alu_vec_pkg;

  localparam int N_LANES_DEF = 4;
  localparam int RES_W_DEF   = 8;

  // Comparison/carry flags captured alongside a result vector.
  typedef struct packed {
    logic carry;
    logic gt;
    logic eq;
    logic lt;
  } flags_t;

  // Serializer control states.
  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

endpackage

// File: rtl/lane_prio_enc.sv
// Lowest-set-bit priority encoder over the pending lane mask.
module lane_prio_enc
  import alu_vec_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  localparam int LANE_W = $clog2(N_LANES)
) (
  input  logic [N_LANES-1:0] mask,
  output logic [LANE_W-1:0]  idx,
  output logic               any_set,
  output logic               single
);

  // Scan from the top down so the lowest set bit wins; flag one-hot masks.
  always_comb begin
    idx = LANE_W'(0);
    for (int i = N_LANES - 1; i >= 0; i--) begin
      idx = mask[i] ? LANE_W'(i) : idx;
    end
    any_set = |mask;
    single  = any_set && ((mask & (mask - N_LANES'(1))) == N_LANES'(0));
  end

endmodule

// File: rtl/alu_result_serializer.sv
// Captures one ALU result vector and streams its enabled lanes, one per
// beat, in ascending lane order over a valid/ready handshake.
module alu_result_serializer
  import alu_vec_pkg::*;
#(
  parameter int N_LANES = N_LANES_DEF,
  parameter int RES_W   = RES_W_DEF,
  localparam int LANE_W = $clog2(N_LANES)
) (
  input  logic                     clk,
  input  logic                     arst,
  input  logic                     load_valid,
  output logic                     load_ready,
  input  logic [N_LANES*RES_W-1:0] res_vec,
  input  logic [N_LANES-1:0]       lane_en,
  input  logic [3:0]               flags_in,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [RES_W-1:0]         out_data,
  output logic [LANE_W-1:0]        out_lane,
  output logic                     out_last,
  output logic [3:0]               out_flags,
  output logic                     empty_drop
);

  state_t                   state_r;
  logic [N_LANES-1:0]       pend_r;
  logic [N_LANES*RES_W-1:0] vec_r;
  flags_t                   flags_r;

  logic                     load_s;
  logic                     take_s;
  logic                     drop_s;
  logic [N_LANES-1:0]       pend_nxt_s;
  logic [N_LANES*RES_W-1:0] vec_nxt_s;
  flags_t                   flags_nxt_s;
  logic [LANE_W-1:0]        enc_idx_s;
  logic                     enc_any_s;
  logic                     enc_single_s;
  logic [RES_W-1:0]         data_nxt_s;

  // Next-state of the capture registers and pending mask: load only in IDLE,
  // retire the presented lane only on a handshake in SEND.
  always_comb begin
    load_s      = 1'b0;
    take_s      = 1'b0;
    pend_nxt_s  = pend_r;
    vec_nxt_s   = vec_r;
    flags_nxt_s = flags_r;
    case (state_r)
      IDLE: begin
        load_s = load_valid;
        if (load_valid) begin
          pend_nxt_s  = lane_en;
          vec_nxt_s   = res_vec;
          flags_nxt_s = flags_t'(flags_in);
        end else begin
          pend_nxt_s  = pend_r;
        end
      end
      SEND: begin
        take_s = out_ready;
        if (out_ready) begin
          pend_nxt_s = pend_r & ~(N_LANES'(1) << out_lane);
        end else begin
          pend_nxt_s = pend_r;
        end
      end
      default: begin
        pend_nxt_s = N_LANES'(0);
      end
    endcase
    drop_s = load_s && (lane_en == N_LANES'(0));
  end

  // Pick the next lane to present from the upcoming pending mask so the
  // outputs can be registered without an extra cycle of latency.
  lane_prio_enc #(.N_LANES(N_LANES)) u_enc (
    .mask    (pend_nxt_s),
    .idx     (enc_idx_s),
    .any_set (enc_any_s),
    .single  (enc_single_s)
  );

  // Select the result field for the upcoming lane.
  always_comb begin
    data_nxt_s = vec_nxt_s[enc_idx_s*RES_W +: RES_W];
  end

  // State, capture registers and registered stream outputs; reset drops any
  // partially drained vector at once.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      state_r    <= IDLE;
      pend_r     <= N_LANES'(0);
      vec_r      <= (N_LANES*RES_W)'(0);
      flags_r    <= 4'b0000;
      out_valid  <= 1'b0;
      out_data   <= RES_W'(0);
      out_lane   <= LANE_W'(0);
      out_last   <= 1'b0;
      out_flags  <= 4'b0000;
      empty_drop <= 1'b0;
      load_ready <= 1'b1;
    end else begin
      state_r    <= enc_any_s ? SEND : IDLE;
      pend_r     <= pend_nxt_s;
      vec_r      <= vec_nxt_s;
      flags_r    <= flags_nxt_s;
      out_valid  <= enc_any_s;
      out_data   <= enc_any_s ? data_nxt_s : RES_W'(0);
      out_lane   <= enc_idx_s;
      out_last   <= enc_single_s;
      out_flags  <= flags_nxt_s;
      empty_drop <= drop_s;
      load_ready <= !enc_any_s;
    end
  end

endmodule

// File: tb/tb_alu_result_serializer.sv
// Directed, table-driven bench for alu_result_serializer.
module tb_alu_result_serializer;

  logic        clk;
  logic        arst;
  logic        load_valid;
  logic        load_ready;
  logic [31:0] res_vec;
  logic [3:0]  lane_en;
  logic [3:0]  flags_in;
  logic        out_valid;
  logic        out_ready;
  logic [7:0]  out_data;
  logic [1:0]  out_lane;
  logic        out_last;
  logic [3:0]  out_flags;
  logic        empty_drop;

  int total;
  int passed;

  alu_result_serializer dut (
    .clk        (clk),
    .arst       (arst),
    .load_valid (load_valid),
    .load_ready (load_ready),
    .res_vec    (res_vec),
    .lane_en    (lane_en),
    .flags_in   (flags_in),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_lane   (out_lane),
    .out_last   (out_last),
    .out_flags  (out_flags),
    .empty_drop (empty_drop)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] vec;
    logic [3:0]  en;
    logic [3:0]  flags;
    int          nb;
    logic [7:0]  lanes;  // expected lane of beat b at [b*2 +: 2]
    logic [31:0] data;   // expected data of beat b at [b*8 +: 8]
  } vec_t;

  vec_t tbl[4];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready();
    int n;
    n = 0;
    while (load_ready !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("wait_load_ready", {31'd0, load_ready}, 32'd1);
  endtask

  // Load one vector with out_ready held high and check every beat.
  task automatic run_vec(input int t);
    wait_ready();
    out_ready  = 1'b1;
    load_valid = 1'b1;
    res_vec    = tbl[t].vec;
    lane_en    = tbl[t].en;
    flags_in   = tbl[t].flags;
    tick();
    load_valid = 1'b0;
    for (int b = 0; b < tbl[t].nb; b++) begin
      chk($sformatf("v%0d_b%0d_valid", t, b), {31'd0, out_valid}, 32'd1);
      chk($sformatf("v%0d_b%0d_lane", t, b), {30'd0, out_lane}, {30'd0, tbl[t].lanes[b*2 +: 2]});
      chk($sformatf("v%0d_b%0d_data", t, b), {24'd0, out_data}, {24'd0, tbl[t].data[b*8 +: 8]});
      chk($sformatf("v%0d_b%0d_last", t, b), {31'd0, out_last}, (b == tbl[t].nb - 1) ? 32'd1 : 32'd0);
      chk($sformatf("v%0d_b%0d_flags", t, b), {28'd0, out_flags}, {28'd0, tbl[t].flags});
      chk($sformatf("v%0d_b%0d_ldrdy", t, b), {31'd0, load_ready}, 32'd0);
      tick();
    end
    chk($sformatf("v%0d_end_valid", t), {31'd0, out_valid}, 32'd0);
    chk($sformatf("v%0d_end_ldrdy", t), {31'd0, load_ready}, 32'd1);
  endtask

  initial begin
    total      = 0;
    passed     = 0;
    arst       = 1'b0;
    load_valid = 1'b0;
    res_vec    = 32'd0;
    lane_en    = 4'd0;
    flags_in   = 4'd0;
    out_ready  = 1'b0;

    tbl[0] = '{vec: 32'h44332211, en: 4'b1111, flags: 4'b0010, nb: 4, lanes: 8'hE4, data: 32'h44332211};
    tbl[1] = '{vec: 32'hDDCCBBAA, en: 4'b0101, flags: 4'b1000, nb: 2, lanes: 8'h08, data: 32'h0000CCAA};
    tbl[2] = '{vec: 32'h807F01FE, en: 4'b1000, flags: 4'b0001, nb: 1, lanes: 8'h03, data: 32'h00000080};
    tbl[3] = '{vec: 32'h12345678, en: 4'b0110, flags: 4'b0100, nb: 2, lanes: 8'h09, data: 32'h00003456};

    // Reset state.
    #12;
    chk("rst_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_ldrdy", {31'd0, load_ready}, 32'd1);
    chk("rst_data", {24'd0, out_data}, 32'd0);
    chk("rst_lane_last", {29'd0, out_lane, out_last}, 32'd0);
    chk("rst_flags_drop", {27'd0, out_flags, empty_drop}, 32'd0);
    @(negedge clk);
    arst = 1'b1;
    tick();

    // Table-driven vectors with out_ready held high.
    for (int t = 0; t < 4; t++) begin
      run_vec(t);
    end

    // Empty mask: no beat, one-cycle empty_drop, load_ready stays high.
    load_valid = 1'b1;
    res_vec    = 32'h55555555;
    lane_en    = 4'b0000;
    flags_in   = 4'b0100;
    tick();
    load_valid = 1'b0;
    chk("empty_valid", {31'd0, out_valid}, 32'd0);
    chk("empty_drop_hi", {31'd0, empty_drop}, 32'd1);
    chk("empty_ldrdy", {31'd0, load_ready}, 32'd1);
    tick();
    chk("empty_drop_lo", {31'd0, empty_drop}, 32'd0);
    chk("empty_valid2", {31'd0, out_valid}, 32'd0);
    chk("empty_ldrdy2", {31'd0, load_ready}, 32'd1);

    // Sparse mask with three cycles of backpressure.
    out_ready  = 1'b0;
    load_valid = 1'b1;
    res_vec    = 32'hA4A3A2A1;
    lane_en    = 4'b1010;
    flags_in   = 4'b0000;
    tick();
    load_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("bp_c%0d_valid", c), {31'd0, out_valid}, 32'd1);
      chk($sformatf("bp_c%0d_lane", c), {30'd0, out_lane}, 32'd1);
      chk($sformatf("bp_c%0d_data", c), {24'd0, out_data}, 32'h000000A2);
      chk($sformatf("bp_c%0d_last", c), {31'd0, out_last}, 32'd0);
      tick();
    end
    out_ready = 1'b1;
    chk("bp_hold_lane", {30'd0, out_lane}, 32'd1);
    tick();
    chk("bp_b1_valid", {31'd0, out_valid}, 32'd1);
    chk("bp_b1_lane", {30'd0, out_lane}, 32'd3);
    chk("bp_b1_data", {24'd0, out_data}, 32'h000000A4);
    chk("bp_b1_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("bp_end_valid", {31'd0, out_valid}, 32'd0);
    chk("bp_end_ldrdy", {31'd0, load_ready}, 32'd1);

    // Load held high during SEND: second vector waits for IDLE.
    load_valid = 1'b1;
    res_vec    = 32'h04030201;
    lane_en    = 4'b1111;
    flags_in   = 4'b1111;
    tick();
    res_vec    = 32'hF4F3F2F1;
    lane_en    = 4'b0011;
    flags_in   = 4'b0000;
    for (int b = 0; b < 4; b++) begin
      chk($sformatf("busy_b%0d_lane", b), {30'd0, out_lane}, b);
      chk($sformatf("busy_b%0d_data", b), {24'd0, out_data}, b + 1);
      chk($sformatf("busy_b%0d_flags", b), {28'd0, out_flags}, 32'hF);
      chk($sformatf("busy_b%0d_ldrdy", b), {31'd0, load_ready}, 32'd0);
      tick();
    end
    chk("busy_idle_ldrdy", {31'd0, load_ready}, 32'd1);
    chk("busy_idle_valid", {31'd0, out_valid}, 32'd0);
    tick();
    load_valid = 1'b0;
    chk("busy2_b0_lane", {30'd0, out_lane}, 32'd0);
    chk("busy2_b0_data", {24'd0, out_data}, 32'h000000F1);
    chk("busy2_b0_flags", {28'd0, out_flags}, 32'd0);
    tick();
    chk("busy2_b1_lane", {30'd0, out_lane}, 32'd1);
    chk("busy2_b1_data", {24'd0, out_data}, 32'h000000F2);
    chk("busy2_b1_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("busy2_end_valid", {31'd0, out_valid}, 32'd0);

    // Reset in the middle of a 4-lane vector.
    load_valid = 1'b1;
    res_vec    = 32'h44332211;
    lane_en    = 4'b1111;
    flags_in   = 4'b0010;
    tick();
    load_valid = 1'b0;
    chk("mrst_b0_lane", {30'd0, out_lane}, 32'd0);
    tick();
    chk("mrst_b1_lane", {30'd0, out_lane}, 32'd1);
    #2;
    arst = 1'b0;
    #1;
    chk("mrst_valid", {31'd0, out_valid}, 32'd0);
    chk("mrst_ldrdy", {31'd0, load_ready}, 32'd1);
    @(negedge clk);
    arst = 1'b1;
    tick();
    chk("mrst_after_valid", {31'd0, out_valid}, 32'd0);
    load_valid = 1'b1;
    res_vec    = 32'h00AB0000;
    lane_en    = 4'b0100;
    flags_in   = 4'b0001;
    tick();
    load_valid = 1'b0;
    chk("mrst_new_valid", {31'd0, out_valid}, 32'd1);
    chk("mrst_new_lane", {30'd0, out_lane}, 32'd2);
    chk("mrst_new_data", {24'd0, out_data}, 32'h000000AB);
    chk("mrst_new_last", {31'd0, out_last}, 32'd1);
    tick();
    chk("mrst_new_end", {31'd0, out_valid}, 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
